// File: rtl/cross_bar_pkg.sv
// ---------------------------------------------------------------------------
// cross_bar_pkg
// Shared sizing, types and FSM state encoding for the crossbar slave-side
// arbitration stage.
//   MASTER_N / SLAVE_N : number of masters / slaves on the crossbar
//   ADDR_W / DATA_W    : address and data widths
//   SEL_W              : width of the slave-select field in the address MSBs
//   MID_W              : width of a master index
// ---------------------------------------------------------------------------
package cross_bar_pkg;

  localparam int MASTER_N = 4;
  localparam int SLAVE_N  = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SEL_W    = $clog2(SLAVE_N);
  localparam int MID_W    = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cross_bar_slave_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts one past the previous
// winner and wraps, so the previous winner has the lowest priority.
//   elig    in  : per-master eligibility
//   rr_last in  : index of the previous winner
//   winner  out : selected master index (0 when nothing is eligible)
//   valid   out : at least one master is eligible
// ---------------------------------------------------------------------------
module rr_arbiter
  import cross_bar_pkg::*;
(
  input  logic [MASTER_N-1:0] elig,
  input  logic [MID_W-1:0]    rr_last,
  output logic [MID_W-1:0]    winner,
  output logic                valid
);

  int idx;

  // Scan rr_last+1 .. rr_last+MASTER_N modulo MASTER_N; first hit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= MASTER_N; k++) begin
      idx = (int'(rr_last) + k) % MASTER_N;
      if (!valid && elig[idx]) begin
        valid  = 1'b1;
        winner = idx[MID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cross_bar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// cross_bar_slave_arbiter
// Per-slave arbitration stage of the crossbar. Masters whose address select
// bits match SLAVE_ID compete round-robin; the winner's transaction is
// registered onto the slave port, and the slave's completion is returned to
// that master as a one-cycle ack with held read data.
//   clk, aresetn         : clock, asynchronous active-low reset
//   master_req/addr/cmd/wdata : per-master request bundle (cmd 1 = write)
//   master_ack           : one-cycle ack pulse to the granted master
//   master_rdata         : read data, held until the next read completes
//   slave_req/addr/cmd/wdata  : registered request toward the slave
//   slave_ack/rdata      : slave completion pulse and read data
//   grant_id             : current or last granted master
//   busy                 : transaction in flight (REQ or ACK)
// ---------------------------------------------------------------------------
module cross_bar_slave_arbiter
  import cross_bar_pkg::*;
#(
  parameter int SLAVE_ID = 0
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [MASTER_N-1:0] master_req,
  input  addr_t [MASTER_N-1:0] master_addr,
  input  logic [MASTER_N-1:0] master_cmd,
  input  data_t [MASTER_N-1:0] master_wdata,
  output logic [MASTER_N-1:0] master_ack,
  output data_t               master_rdata,
  output logic                slave_req,
  output addr_t               slave_addr,
  output logic                slave_cmd,
  output data_t               slave_wdata,
  input  logic                slave_ack,
  input  data_t               slave_rdata,
  output logic [MID_W-1:0]    grant_id,
  output logic                busy
);

  localparam logic [SEL_W-1:0] MY_SEL  = SEL_W'(SLAVE_ID);
  localparam logic [MID_W-1:0] LAST_RST = MID_W'(MASTER_N - 1);

  arb_state_t          state, state_nxt;
  logic [MASTER_N-1:0] drop_wait, drop_wait_nxt, drop_set;
  logic [MASTER_N-1:0] elig;
  logic [MID_W-1:0]    rr_last, rr_last_nxt;
  logic [MID_W-1:0]    pick;
  logic                pick_valid;

  logic [MID_W-1:0]    grant_nxt;
  addr_t               addr_nxt;
  logic                cmd_nxt;
  data_t               wdata_nxt;
  logic                sreq_nxt;
  logic [MASTER_N-1:0] mack_nxt;
  data_t               rdata_nxt;

  // A master that still holds req after its ack is masked until its req is
  // seen low, since its slower clock may not have dropped req yet.
  always_comb begin
    for (int m = 0; m < MASTER_N; m++) begin
      elig[m] = master_req[m] &&
                (master_addr[m][ADDR_W-1 -: SEL_W] == MY_SEL) &&
                !drop_wait[m];
    end
  end

  rr_arbiter u_rr_arbiter (
    .elig    (elig),
    .rr_last (rr_last),
    .winner  (pick),
    .valid   (pick_valid)
  );

  // Next-state and next-output logic; requests are only looked at in IDLE,
  // and slave_ack is only honoured in REQ.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_id;
    addr_nxt    = slave_addr;
    cmd_nxt     = slave_cmd;
    wdata_nxt   = slave_wdata;
    sreq_nxt    = slave_req;
    mack_nxt    = '0;
    rdata_nxt   = master_rdata;
    rr_last_nxt = rr_last;
    drop_set    = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt   = pick;
          addr_nxt    = master_addr[pick];
          cmd_nxt     = master_cmd[pick];
          wdata_nxt   = master_wdata[pick];
          sreq_nxt    = 1'b1;
          rr_last_nxt = pick;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (slave_ack) begin
          sreq_nxt           = 1'b0;
          mack_nxt[grant_id] = 1'b1;
          drop_set[grant_id] = 1'b1;
          if (!slave_cmd) begin
            rdata_nxt = slave_rdata;
          end
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A low req always clears the mask, even in the cycle it would be set.
    drop_wait_nxt = (drop_wait | drop_set) & master_req;
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      drop_wait    <= '0;
      rr_last      <= LAST_RST;
      grant_id     <= '0;
      slave_addr   <= '0;
      slave_cmd    <= 1'b0;
      slave_wdata  <= '0;
      slave_req    <= 1'b0;
      master_ack   <= '0;
      master_rdata <= '0;
    end else begin
      state        <= state_nxt;
      drop_wait    <= drop_wait_nxt;
      rr_last      <= rr_last_nxt;
      grant_id     <= grant_nxt;
      slave_addr   <= addr_nxt;
      slave_cmd    <= cmd_nxt;
      slave_wdata  <= wdata_nxt;
      slave_req    <= sreq_nxt;
      master_ack   <= mack_nxt;
      master_rdata <= rdata_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cross_bar_slave_arbiter
// Directed cycle table for the documented scenarios, followed by randomized
// traffic compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_cross_bar_slave_arbiter;
  import cross_bar_pkg::*;

  logic                clk = 1'b0;
  logic                aresetn = 1'b0;
  logic [3:0]          master_req = '0;
  addr_t [3:0]         master_addr = '0;
  logic [3:0]          master_cmd = '0;
  data_t [3:0]         master_wdata = '0;
  logic [3:0]          master_ack;
  data_t               master_rdata;
  logic                slave_req;
  addr_t               slave_addr;
  logic                slave_cmd;
  data_t               slave_wdata;
  logic                slave_ack = 1'b0;
  data_t               slave_rdata = '0;
  logic [1:0]          grant_id;
  logic                busy;

  int vectors = 0;
  int miscompares = 0;

  cross_bar_slave_arbiter #(.SLAVE_ID(0)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .master_req   (master_req),
    .master_addr  (master_addr),
    .master_cmd   (master_cmd),
    .master_wdata (master_wdata),
    .master_ack   (master_ack),
    .master_rdata (master_rdata),
    .slave_req    (slave_req),
    .slave_addr   (slave_addr),
    .slave_cmd    (slave_cmd),
    .slave_wdata  (slave_wdata),
    .slave_ack    (slave_ack),
    .slave_rdata  (slave_rdata),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [3:0]  cmd;
    logic [3:0]  sel1;
    bit          sack;
    logic [31:0] srdata;
    bit          e_sreq;
    logic [3:0]  e_mack;
    logic [1:0]  e_gid;
    bit          e_busy;
    logic [31:0] e_rdata;
    bit          chk_pay;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [3:0] req, logic [3:0] cmd,
                              logic [3:0] sel1, bit sack, logic [31:0] srdata,
                              bit e_sreq, logic [3:0] e_mack, int e_gid,
                              bit e_busy, logic [31:0] e_rdata, bit chk);
    vec_t v;
    v.rst = rst; v.req = req; v.cmd = cmd; v.sel1 = sel1;
    v.sack = sack; v.srdata = srdata;
    v.e_sreq = e_sreq; v.e_mack = e_mack; v.e_gid = 2'(e_gid);
    v.e_busy = e_busy; v.e_rdata = e_rdata; v.chk_pay = chk;
    return v;
  endfunction

  // Fixed per-master addresses; sel=1 redirects the master to slave 1.
  function automatic logic [31:0] addr_of(int m, bit sel);
    logic [31:0] a;
    case (m)
      0:       a = 32'h0000_0010;
      3:       a = 32'h0000_0030;
      default: a = 32'h0000_0000;
    endcase
    if (sel) a[31:30] = 2'b01;
    return a;
  endfunction

  function automatic logic [31:0] wdata_of(int m);
    case (m)
      0:       return 32'hdead_c0de;
      1:       return 32'h2222_2222;
      2:       return 32'h3333_3333;
      default: return 32'h4444_4444;
    endcase
  endfunction

  // Drive one table row; when reset is asserted, confirm the outputs clear
  // without waiting for a clock edge.
  task automatic applyStimulus(input vec_t v);
    aresetn    = !v.rst;
    master_req = v.req;
    master_cmd = v.cmd;
    for (int m = 0; m < 4; m++) begin
      master_addr[m]  = addr_of(m, v.sel1[m]);
      master_wdata[m] = wdata_of(m);
    end
    slave_ack   = v.sack;
    slave_rdata = v.srdata;
    if (v.rst) begin
      #1;
      vectors++;
      if (slave_req !== 1'b0 || busy !== 1'b0 || master_ack !== 4'b0 ||
          grant_id !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL async_reset: got sreq=%b busy=%b ack=%b gid=%0d, expected all 0",
                 slave_req, busy, master_ack, grant_id);
      end
    end
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    int g;
    vectors++;
    if (slave_req !== v.e_sreq || master_ack !== v.e_mack ||
        grant_id !== v.e_gid || busy !== v.e_busy || master_rdata !== v.e_rdata) begin
      miscompares++;
      $display("[TB] FAIL row%0d: got sreq=%b ack=%b gid=%0d busy=%b rdata=%h, expected sreq=%b ack=%b gid=%0d busy=%b rdata=%h",
               row, slave_req, master_ack, grant_id, busy, master_rdata,
               v.e_sreq, v.e_mack, v.e_gid, v.e_busy, v.e_rdata);
    end
    if (v.chk_pay) begin
      g = int'(v.e_gid);
      vectors++;
      if (slave_addr !== addr_of(g, v.sel1[g]) || slave_wdata !== wdata_of(g) ||
          slave_cmd !== v.cmd[g]) begin
        miscompares++;
        $display("[TB] FAIL payload row%0d: got addr=%h wdata=%h cmd=%b, expected addr=%h wdata=%h cmd=%b",
                 row, slave_addr, slave_wdata, slave_cmd,
                 addr_of(g, v.sel1[g]), wdata_of(g), v.cmd[g]);
      end
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          cur;
  int          ack_m;
  bit          ack_cyc;
  int          last;
  bit  [3:0]   waiting;
  logic [31:0] m_rdata, m_addr, m_wdata;
  bit          m_cmd;
  int          m_gid;

  task automatic modelReset();
    cur = -1; ack_m = 0; ack_cyc = 0; last = 3; waiting = '0;
    m_rdata = '0; m_addr = '0; m_wdata = '0; m_cmd = 0; m_gid = 0;
  endtask

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic modelStep();
    bit [3:0] el;
    bit [3:0] new_wait;
    int       win;
    for (int m = 0; m < 4; m++)
      el[m] = master_req[m] && (master_addr[m][31:30] == 2'b00) && !waiting[m];
    new_wait = waiting;
    if (ack_cyc) begin
      ack_cyc = 0;
    end else if (cur >= 0) begin
      if (slave_ack) begin
        ack_cyc = 1;
        ack_m = cur;
        new_wait[cur] = 1'b1;
        if (!m_cmd) m_rdata = slave_rdata;
        cur = -1;
      end
    end else begin
      win = -1;
      for (int k = 1; k <= 4; k++)
        if (win < 0 && el[(last + k) % 4]) win = (last + k) % 4;
      if (win >= 0) begin
        cur = win; last = win; m_gid = win;
        m_addr = master_addr[win]; m_wdata = master_wdata[win];
        m_cmd = master_cmd[win];
      end
    end
    for (int m = 0; m < 4; m++) waiting[m] = new_wait[m] && master_req[m];
  endtask

  // ---------------- random agents ----------------
  int  ag_hold[4];
  bit  ag_active[4];
  bit  ag_acked[4];
  bit  sack_prev;

  task automatic driveRandom();
    logic [3:0] exp_mack;
    exp_mack = ack_cyc ? (4'b0001 << ack_m) : 4'b0000;
    for (int m = 0; m < 4; m++) begin
      if (!master_req[m]) begin
        if ($urandom_range(0, 3) == 0) begin
          master_req[m]   = 1'b1;
          master_addr[m]  = $urandom;
          master_addr[m][31:30] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          master_cmd[m]   = 1'($urandom_range(0, 1));
          master_wdata[m] = $urandom;
          ag_acked[m] = 0;
        end
      end else if (!ag_acked[m]) begin
        if (exp_mack[m]) begin
          ag_acked[m] = 1;
          ag_hold[m] = $urandom_range(0, 5);
          if (ag_hold[m] == 0) master_req[m] = 1'b0;
        end else if ($urandom_range(0, 31) == 0) begin
          master_req[m] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          master_addr[m][7:0] = 8'($urandom);
        end
      end else begin
        ag_hold[m]--;
        if (ag_hold[m] <= 0) master_req[m] = 1'b0;
      end
    end
    slave_rdata = $urandom;
    if (sack_prev) slave_ack = 1'b0;
    else if (cur >= 0 && $urandom_range(0, 2) == 0) slave_ack = 1'b1;
    else slave_ack = ($urandom_range(0, 19) == 0);
    sack_prev = slave_ack;
  endtask

  task automatic checkRandom(input int cyc);
    logic [3:0] e_mack;
    bit         e_sreq, e_busy;
    bit         bad;
    e_sreq = (cur >= 0);
    e_busy = (cur >= 0) || ack_cyc;
    e_mack = ack_cyc ? (4'b0001 << ack_m) : 4'b0000;
    bad = (slave_req !== e_sreq) || (master_ack !== e_mack) || (busy !== e_busy) ||
          (grant_id !== 2'(m_gid)) || (master_rdata !== m_rdata);
    if (e_sreq)
      bad = bad || (slave_addr !== m_addr) || (slave_wdata !== m_wdata) || (slave_cmd !== m_cmd);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL random cycle%0d: got sreq=%b ack=%b busy=%b gid=%0d rdata=%h addr=%h, expected sreq=%b ack=%b busy=%b gid=%0d rdata=%h addr=%h",
               cyc, slave_req, master_ack, busy, grant_id, master_rdata, slave_addr,
               e_sreq, e_mack, e_busy, m_gid, m_rdata, m_addr);
    end
  endtask

  localparam logic [31:0] RD0 = 32'ha5a5_1234;
  localparam logic [31:0] RD1 = 32'h1234_5678;

  initial begin
    // Reset and single write from M0
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0,            0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 0,            1, 4'b0000, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 0,            1, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 0,            1, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 32'hffff_0000, 0, 4'b0001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0,            0, 4'b0000, 0, 0, 0, 0));
    // Read by M2, then a stale slave_ack in IDLE
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 0, 0,            1, 4'b0000, 2, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 1, RD0,          0, 4'b0100, 2, 1, RD0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0,            0, 4'b0000, 2, 0, RD0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 32'hffff_ffff, 0, 4'b0000, 2, 0, RD0, 0));
    // Decode filter: M1 targets slave 1
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 0, 0,            0, 4'b0000, 2, 0, RD0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 0, 0,            0, 4'b0000, 2, 0, RD0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0,            0, 4'b0000, 2, 0, RD0, 0));
    // Contention after reset: order 0,1,2,3 then 0 again
    tbl.push_back(mk(1, 4'b0000, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 0,            1, 4'b0000, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 0,            0, 4'b0001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1110, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1110, 4'b1111, 4'b0000, 0, 0,            1, 4'b0000, 1, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1110, 4'b1111, 4'b0000, 1, 0,            0, 4'b0010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1100, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1100, 4'b1111, 4'b0000, 0, 0,            1, 4'b0000, 2, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1100, 4'b1111, 4'b0000, 1, 0,            0, 4'b0100, 2, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 2, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1111, 4'b0000, 0, 0,            1, 4'b0000, 3, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b1111, 4'b0000, 1, 0,            0, 4'b1000, 3, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 3, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 0,            1, 4'b0000, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 0,            0, 4'b0001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 0, 0, 0, 0));
    // Hold-after-ack: M0 keeps req high, must not be re-granted
    tbl.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 0, 0,            1, 4'b0000, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b1111, 4'b0000, 1, 0,            0, 4'b0001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b1111, 4'b0000, 0, 0,            1, 4'b0000, 1, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b1111, 4'b0000, 1, 0,            0, 4'b0010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 0, 0,            1, 4'b0000, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0001, 4'b1111, 4'b0000, 1, 0,            0, 4'b0001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 0,            0, 4'b0000, 0, 0, 0, 0));
    // Reset while in REQ, then a fresh read from M0 with a stale ack
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0,            1, 4'b0000, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 1, 32'h9999_9999, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 32'h9999_9999, 1, 4'b0000, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, RD1,          0, 4'b0001, 0, 1, RD1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0,            0, 4'b0000, 0, 0, RD1, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput(tbl[i], i);
    end

    // Randomized traffic against the reference model
    aresetn = 1'b0;
    master_req = '0; slave_ack = 1'b0;
    for (int m = 0; m < 4; m++) begin ag_hold[m] = 0; ag_active[m] = 0; ag_acked[m] = 0; end
    sack_prev = 0;
    modelReset();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      driveRandom();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkRandom(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cross_bar_slave_arbiter.md
Name: cross_bar_slave_arbiter

Overview:
Per-slave arbitration and sequencing stage of cross_bar_top; cross_bar_top instantiates one per slave port (SLAVE_ID = 0..SLAVE_N-1).
- Decodes which masters target this slave from the address select bits.
- Grants one master at a time, round-robin, and drives that master's transaction onto the slave req/ack port.
- Returns a single-cycle ack and held read data to the granted master.

Parameters:
MASTER_N, 4, number of requesting masters
SLAVE_N, 4, number of slaves; SEL_W = $clog2(SLAVE_N)
SLAVE_ID, 0, slave index this instance serves; matches master_addr[ADDR_W-1 -: SEL_W]
ADDR_W, 32, address width (addr_t)
DATA_W, 32, data width (data_t)

Ports:
clk  in  1  device clock; all logic on posedge
aresetn  in  1  asynchronous active-low reset
master_req  in  MASTER_N  per-master request; held high until that master's ack
master_addr  in  MASTER_N x ADDR_W  per-master address (addr_t packed array)
master_cmd  in  MASTER_N  per-master command: 1 = write, 0 = read
master_wdata  in  MASTER_N x DATA_W  per-master write data
master_ack  out  MASTER_N  one-cycle ack pulse to the granted master
master_rdata  out  DATA_W  read data; valid from the ack pulse, held until the next read completes
slave_req  out  1  request to slave
slave_addr  out  ADDR_W  registered address of the granted master
slave_cmd  out  1  registered command
slave_wdata  out  DATA_W  registered write data
slave_ack  in  1  slave completion; single-cycle pulse
slave_rdata  in  DATA_W  slave read data; valid with slave_ack
grant_id  out  $clog2(MASTER_N)  index of the current or last granted master
busy  out  1  high in states REQ and ACK

Behaviour:
- Eligibility: elig[m] = master_req[m] & (master_addr[m][ADDR_W-1 -: SEL_W] == SLAVE_ID) & ~drop_wait[m].
- Reset, asynchronous: every output 0; state = IDLE; drop_wait = 0; rr_last = MASTER_N-1, so master 0 has highest priority first.
- State IDLE:
  - If any elig: pick the first eligible index scanning rr_last+1, rr_last+2, ... modulo MASTER_N.
  - Register grant_id, slave_addr, slave_cmd and slave_wdata from that master; set slave_req = 1; rr_last = winner; go to REQ.
  - slave_req is high in the cycle after the request was sampled (one-cycle latency).
- State REQ:
  - slave_req and the slave_* payload stay constant.
  - On slave_ack = 1: slave_req = 0 next cycle; master_ack[grant_id] = 1 next cycle; master_rdata <= slave_rdata if slave_cmd = 0, otherwise unchanged; drop_wait[grant_id] = 1; go to ACK.
  - No timeout: REQ waits indefinitely.
- State ACK: lasts exactly one cycle with master_ack pulsing; master_ack returns to 0; go to IDLE.
- drop_wait[m]: cleared in any cycle where master_req[m] = 0. This prevents re-granting a master that has not yet dropped req after its ack (master clocks are slower and asynchronous to clk).
- Minimum gap: slave_req is low for at least 2 cycles between transactions (ACK, then IDLE).
- slave_ack in IDLE or ACK is ignored.
- Request changes:
  - A master changing req or addr while granted does not affect the slave_* payload, which is captured at grant.
  - A master whose req drops while in REQ still gets its ack pulse.
- Simultaneous slave_ack and new requests: requests are only evaluated in IDLE.
- Reset mid-transaction: outputs clear immediately; the transaction is abandoned and no ack is issued.
- busy = (state != IDLE).

Decomposition:
- cross_bar_pkg holds:
  - MASTER_N, SLAVE_N, ADDR_W, DATA_W;
  - addr_t and data_t;
  - SEL_W;
  - state enum arb_state_t {IDLE, REQ, ACK}.
- One sub-module, rr_arbiter: combinational round-robin pick from (elig, rr_last) producing winner index and valid. The FSM and registers stay in the top.

Test Plan:
- Single write: M0 req, addr 0x0000_0010, wdata 0xdeadc0de (SLAVE_ID 0); slave acks 3 cycles after slave_req.
  -> slave_req high 1 cycle after req, addr and data match, master_ack[0] one pulse 1 cycle after slave_ack, grant_id = 0.
- Read: M2 reads 0x0000_0000; slave returns 0xa5a5_1234.
  -> master_rdata = 0xa5a5_1234 from the ack pulse and held after; master_ack = 4'b0100 pulse.
- Contention: M0-M3 all req this slave in the same cycle, each held until acked, then dropped.
  -> grant order 0, 1, 2, 3; next round after re-request starts at 0; slave_req gap ≥ 2 cycles.
- Decode filter: M1 addr 0x4000_0000 (SEL 1) with SLAVE_ID = 0.
  -> no slave_req, master_ack stays 0.
- Hold-after-ack: M0 keeps req high 5 cycles after its ack while M1 is also requesting.
  -> M1 granted next; M0 not re-granted until its req is seen low then high again.
- Reset mid-operation: aresetn low while in REQ.
  -> all outputs 0 immediately; after release, M0 first; stale slave_ack ignored.
